// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: receives a framed program image over UART, writes it to
// instruction memory, checks the byte checksum and then releases the core.
//
// state | meaning
// IDLE  | waiting for SYNC_BYTE, other bytes dropped
// LEN0  | expecting length low byte
// LEN1  | expecting length high byte, range check
// DATA  | assembling payload words and writing them
// CSUM  | expecting checksum byte
// ACK   | presenting reply byte until transmitter accepts it
// RUN   | image loaded, core released; left only by reset
module boot_loader_ctrl #(
   parameter int          MEM_WORDS      = 4096,
   parameter int          ADDR_W         = $clog2(MEM_WORDS),
   parameter int          TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter logic [7:0]  ACK_OK         = 8'h4B,
   parameter logic [7:0]  ACK_ERR        = 8'h45
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clk_en,
   input  logic              i_rx_valid,
   input  logic [7:0]        i_rx_data,
   output logic              o_tx_valid,
   output logic [7:0]        o_tx_data,
   input  logic              i_tx_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   output logic              o_core_rst,
   output logic              o_booted,
   output logic              o_error
);

   localparam int              TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [16:0]     MAX_LEN  = 17'(MEM_WORDS);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_ACK, S_RUN
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         len_q, len_d;
   logic [ADDR_W-1:0]   widx_q, widx_d;
   logic [1:0]          bcnt_q, bcnt_d;
   logic [23:0]         word_q, word_d;
   logic [7:0]          csum_q, csum_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                tx_valid_q, tx_valid_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic                core_rst_q, core_rst_d;
   logic                booted_q, booted_d;
   logic                error_q, error_d;

   logic [15:0] len_new;
   logic        last_word;

   assign len_new   = {i_rx_data, len_q[7:0]};
   assign last_word = (17'(widx_q) + 17'd1) == 17'(len_q);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      widx_d      = widx_q;
      bcnt_d      = bcnt_q;
      word_d      = word_q;
      csum_d      = csum_q;
      tmo_d       = tmo_q;
      tx_valid_d  = tx_valid_q;
      tx_data_d   = tx_data_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      core_rst_d  = core_rst_q;
      booted_d    = booted_q;
      error_d     = error_q;

      case (state_q)
         S_IDLE: begin
            if (i_rx_valid && i_rx_data == SYNC_BYTE) begin
               error_d = 1'b0;
               csum_d  = 8'h00;
               widx_d  = '0;
               bcnt_d  = 2'd0;
               tmo_d   = TMO_LOAD;
               state_d = S_LEN0;
            end
         end
         S_ACK: begin
            if (i_tx_ready) begin
               tx_valid_d = 1'b0;
               if (tx_data_q == ACK_OK) begin
                  state_d    = S_RUN;
                  core_rst_d = 1'b0;
                  booted_d   = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_RUN: ;
         default: begin
            // Timeout wins over a byte arriving on the same cycle.
            if (tmo_q == '0) begin
               state_d = S_IDLE;
               error_d = 1'b1;
            end else if (!i_rx_valid) begin
               tmo_d = tmo_q - TMO_W'(1);
            end else begin
               tmo_d = TMO_LOAD;
               case (state_q)
                  S_LEN0: begin
                     len_d   = {8'h00, i_rx_data};
                     state_d = S_LEN1;
                  end
                  S_LEN1: begin
                     len_d = len_new;
                     if (17'(len_new) > MAX_LEN) begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = ACK_ERR;
                        error_d    = 1'b1;
                        state_d    = S_ACK;
                     end else if (len_new == 16'd0) begin
                        state_d = S_CSUM;
                     end else begin
                        state_d = S_DATA;
                     end
                  end
                  S_DATA: begin
                     csum_d = csum_q + i_rx_data;
                     word_d = {i_rx_data, word_q[23:8]};
                     bcnt_d = bcnt_q + 2'd1;
                     if (bcnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = widx_q;
                        mem_wdata_d = {i_rx_data, word_q};
                        if (last_word) state_d = S_CSUM;
                        else           widx_d  = widx_q + ADDR_W'(1);
                     end
                  end
                  S_CSUM: begin
                     tx_valid_d = 1'b1;
                     state_d    = S_ACK;
                     if (i_rx_data == csum_q) begin
                        tx_data_d = ACK_OK;
                     end else begin
                        tx_data_d = ACK_ERR;
                        error_d   = 1'b1;
                     end
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         widx_q      <= '0;
         bcnt_q      <= '0;
         word_q      <= '0;
         csum_q      <= '0;
         tmo_q       <= '0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         core_rst_q  <= 1'b1;
         booted_q    <= 1'b0;
         error_q     <= 1'b0;
      end else if (i_clk_en) begin
         state_q     <= state_d;
         len_q       <= len_d;
         widx_q      <= widx_d;
         bcnt_q      <= bcnt_d;
         word_q      <= word_d;
         csum_q      <= csum_d;
         tmo_q       <= tmo_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         core_rst_q  <= core_rst_d;
         booted_q    <= booted_d;
         error_q     <= error_d;
      end
   end

   assign o_tx_valid  = tx_valid_q;
   assign o_tx_data   = tx_data_q;
   assign o_mem_we    = mem_we_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_wdata_q;
   assign o_core_rst  = core_rst_q;
   assign o_booted    = booted_q;
   assign o_error     = error_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed and randomized bench for boot_loader_ctrl with a frame-level
// reference model (expected writes, reply byte and final status per frame).
module tb_boot_loader_ctrl;
   localparam int MEM_WORDS = 4096;
   localparam int ADDR_W    = 12;
   localparam int TMO       = 40;

   logic              i_clk = 1'b0;
   logic              i_rst = 1'b0;
   logic              i_clk_en = 1'b1;
   logic              i_rx_valid = 1'b0;
   logic [7:0]        i_rx_data = 8'h00;
   logic              i_tx_ready = 1'b0;
   logic              o_tx_valid;
   logic [7:0]        o_tx_data;
   logic              o_mem_we;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [31:0]       o_mem_wdata;
   logic              o_core_rst;
   logic              o_booted;
   logic              o_error;

   boot_loader_ctrl #(
      .MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO),
      .SYNC_BYTE(8'hA5), .ACK_OK(8'h4B), .ACK_ERR(8'h45)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en),
      .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
      .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
      .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .o_core_rst(o_core_rst), .o_booted(o_booted), .o_error(o_error)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;
   int duty_mode = 0;   // 0: always enabled, 1: about 1-in-3, 2: about 1-in-2
   int rdy_hold  = 0;   // cycles of i_tx_ready=0 before it may rise
   bit rdy_rand  = 0;
   bit gaps      = 0;

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [7:0]  tx_q[$];
   int          stab_err = 0;
   logic        hold_pend = 1'b0;
   logic [7:0]  held = 8'h00;

   // Inputs change just after posedge, so at negedge they show what the next edge will see.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (i_clk_en && o_mem_we) begin
            wr_addr_q.push_back(32'(o_mem_addr));
            wr_data_q.push_back(o_mem_wdata);
         end
         if (o_tx_valid) begin
            if (hold_pend && o_tx_data !== held) stab_err++;
            if (i_clk_en && i_tx_ready) begin
               tx_q.push_back(o_tx_data);
               hold_pend = 1'b0;
            end else begin
               hold_pend = 1'b1;
               held      = o_tx_data;
            end
         end else begin
            hold_pend = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic pick_en();
      case (duty_mode)
         0:       return 1'b1;
         1:       return ($urandom_range(2) == 0);
         default: return ($urandom_range(1) == 1);
      endcase
   endfunction

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         i_clk_en = pick_en();
         step();
      end
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      step();
      step();
      i_rst = 1'b0;
      step();
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic acc;
      int   tries;
      tries = 0;
      acc   = 1'b0;
      i_rx_valid = 1'b1;
      i_rx_data  = b;
      while (!acc && tries < 1000) begin
         i_clk_en = pick_en();
         acc = i_clk_en;
         step();
         tries++;
      end
      i_rx_valid = 1'b0;
      i_clk_en   = pick_en();
      if (!acc) begin
         $display("FAIL send_byte: byte %h never accepted", b);
         $fatal(1, "stimulus stuck");
      end
      if (gaps) idle($urandom_range(2));
   endtask

   task automatic wait_tx(output logic [7:0] b, output bit got);
      int n;
      n   = 0;
      got = 0;
      b   = 8'h00;
      while (tx_q.size() == 0 && n < 400) begin
         i_tx_ready = (n < rdy_hold) ? 1'b0 : (rdy_rand ? 1'($urandom_range(1)) : 1'b1);
         i_clk_en   = pick_en();
         step();
         n++;
      end
      i_tx_ready = 1'b0;
      if (tx_q.size() > 0) begin
         b   = tx_q.pop_front();
         got = 1;
      end
   endtask

   task automatic do_frame(input logic [15:0] len, input logic [7:0] pl[$],
                           input logic [7:0] cs, input int ngarb, input string tag);
      logic [7:0]  b;
      logic [7:0]  exp_tx;
      logic [31:0] exp_w;
      bit          got;
      bit          ok;
      int          sum;
      int          nw;
      sum = 0;
      foreach (pl[i]) sum += int'(pl[i]);
      if (int'(len) > MEM_WORDS) begin
         ok = 0;
         nw = 0;
      end else begin
         ok = (cs == 8'(sum % 256));
         nw = int'(len);
      end
      exp_tx = ok ? 8'h4B : 8'h45;
      wr_addr_q.delete();
      wr_data_q.delete();
      tx_q.delete();
      repeat (ngarb) begin
         b = 8'($urandom_range(255));
         if (b == 8'hA5) b = 8'h00;
         send_byte(b);
      end
      send_byte(8'hA5);
      send_byte(len[7:0]);
      send_byte(len[15:8]);
      if (int'(len) <= MEM_WORDS) begin
         foreach (pl[i]) send_byte(pl[i]);
         send_byte(cs);
      end
      wait_tx(b, got);
      check({tag, "_tx_seen"}, 32'(got), 32'd1);
      check({tag, "_tx_byte"}, 32'(b), 32'(exp_tx));
      check({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'(nw));
      for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
         exp_w = {pl[4*i+3], pl[4*i+2], pl[4*i+1], pl[4*i]};
         check($sformatf("%s_wr%0d_addr", tag, i), wr_addr_q[i], 32'(i));
         check($sformatf("%s_wr%0d_data", tag, i), wr_data_q[i], exp_w);
      end
      check({tag, "_tx_valid_drop"}, 32'(o_tx_valid), 32'd0);
      check({tag, "_core_rst"}, 32'(o_core_rst), ok ? 32'd0 : 32'd1);
      check({tag, "_booted"},   32'(o_booted),   ok ? 32'd1 : 32'd0);
      check({tag, "_error"},    32'(o_error),    ok ? 32'd0 : 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_valid"},  32'(o_tx_valid), 32'd0);
      check({tag, "_tx_data"},   32'(o_tx_data),  32'd0);
      check({tag, "_mem_we"},    32'(o_mem_we),   32'd0);
      check({tag, "_mem_addr"},  32'(o_mem_addr), 32'd0);
      check({tag, "_mem_wdata"}, o_mem_wdata,     32'd0);
      check({tag, "_core_rst"},  32'(o_core_rst), 32'd1);
      check({tag, "_booted"},    32'(o_booted),   32'd0);
      check({tag, "_error"},     32'(o_error),    32'd0);
   endtask

   logic [7:0] pl[$];
   logic [7:0] empty_pl[$];
   logic [7:0] b;
   bit         got;
   int         len;

   initial begin
      #2 i_rst = 1'b1;
      #1 check_reset_outputs("por");
      step();
      i_rst = 1'b0;
      step();

      // Known-good two-word frame
      pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      do_frame(16'd2, pl, 8'h64, 2, "good");

      // Async reset between edges from the booted state
      @(negedge i_clk);
      #2 i_rst = 1'b1;
      #1 check_reset_outputs("async_rst");
      step();
      i_rst = 1'b0;
      step();

      // Bad checksum, then recovery without reset
      do_frame(16'd2, pl, 8'h00, 0, "badcs");
      do_frame(16'd2, pl, 8'h64, 1, "recover");
      do_reset();

      // Oversize length: reply right after LEN1, no writes
      do_frame(16'(MEM_WORDS + 1), empty_pl, 8'h00, 0, "oversize");
      do_reset();

      // Timeout boundary from LEN1
      tx_q.delete();
      send_byte(8'hA5);
      send_byte(8'h01);
      idle(TMO - 1);
      check("tmo_before", 32'(o_error), 32'd0);
      idle(1);
      check("tmo_at", 32'(o_error), 32'd1);
      i_tx_ready = 1'b1;
      idle(5);
      i_tx_ready = 1'b0;
      check("tmo_no_tx", 32'(tx_q.size()), 32'd0);
      do_frame(16'd0, empty_pl, 8'h00, 0, "zero_len");
      do_reset();

      // Slow enable, stalled transmitter
      duty_mode = 1;
      rdy_hold  = 10;
      do_frame(16'd2, pl, 8'h64, 0, "slow_good");
      do_reset();
      do_frame(16'd2, pl, 8'h00, 0, "slow_bad");

      // Reset in the middle of DATA after one word was written
      wr_addr_q.delete();
      wr_data_q.delete();
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h00);
      foreach (pl[i]) if (i < 5) send_byte(pl[i]);
      check("abort_wr_count", 32'(wr_addr_q.size()), 32'd1);
      if (wr_data_q.size() > 0) check("abort_wr_data", wr_data_q[0], 32'h44332211);
      @(negedge i_clk);
      #2 i_rst = 1'b1;
      #1 check("abort_core_rst", 32'(o_core_rst), 32'd1);
      check("abort_mem_we", 32'(o_mem_we), 32'd0);
      step();
      i_rst = 1'b0;
      step();
      do_frame(16'd2, pl, 8'h64, 0, "after_abort");
      do_reset();

      // Randomized frames
      for (int t = 0; t < 25; t++) begin
         duty_mode = $urandom_range(2);
         rdy_hold  = $urandom_range(5);
         rdy_rand  = 1'($urandom_range(1));
         gaps      = 1'($urandom_range(1));
         pl.delete();
         if ($urandom_range(9) == 0) len = MEM_WORDS + 1 + $urandom_range(2);
         else                        len = $urandom_range(6);
         if (len <= MEM_WORDS)
            for (int k = 0; k < 4 * len; k++) pl.push_back(8'($urandom_range(255)));
         begin
            int s;
            s = 0;
            foreach (pl[k]) s += int'(pl[k]);
            b = ($urandom_range(9) < 6) ? 8'(s) : 8'(s + 1 + $urandom_range(254));
         end
         do_frame(16'(len), pl, b, $urandom_range(3), $sformatf("rnd%0d", t));
         if (o_booted) do_reset();
      end

      check("tx_data_stable", 32'(stab_err), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
